// File: rtl/lbm_pkg.sv
// lbm_pkg: shared types and defaults for the lattice streaming/collision blocks.
//   - dir_e      : distribution direction index, one BRAM per direction
//   - state_e    : frame sequencer states
//   - NUM_DIRS   : number of distribution lanes
//   - DEF_*      : default grid size
package lbm_pkg;

  localparam int NUM_DIRS    = 9;
  localparam int DEF_HPIXELS = 205;
  localparam int DEF_VPIXELS = 154;

  typedef enum logic [3:0] {
    CENTER = 4'd0,
    N      = 4'd1,
    NE     = 4'd2,
    E      = 4'd3,
    SE     = 4'd4,
    S      = 4'd5,
    SW     = 4'd6,
    W      = 4'd7,
    NW     = 4'd8
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_e;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: row-major (hor, vert) cell counter over an HPIXELS x VPIXELS grid.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset, counters to (0,0)
//   clr_i   synchronous clear to (0,0), has priority over en_i
//   en_i    advance one cell; hor wraps into vert, the last cell wraps to (0,0)
//   hor_o   current column
//   vert_o  current row
//   last_o  current cell is (HPIXELS-1, VPIXELS-1)
module raster_counter
  import lbm_pkg::*;
#(
  parameter int HPIXELS = DEF_HPIXELS,
  parameter int VPIXELS = DEF_VPIXELS,
  localparam int HOR_SIZE  = $clog2(HPIXELS),
  localparam int VERT_SIZE = $clog2(VPIXELS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic [HOR_SIZE-1:0]  hor_o,
  output logic [VERT_SIZE-1:0] vert_o,
  output logic                 last_o
);

  logic [HOR_SIZE-1:0]  hor_q, hor_d;
  logic [VERT_SIZE-1:0] vert_q, vert_d;
  logic                 hor_end;
  logic                 vert_end;

  assign hor_end  = (hor_q == HOR_SIZE'(HPIXELS - 1));
  assign vert_end = (vert_q == VERT_SIZE'(VPIXELS - 1));

  always_comb begin
    hor_d  = hor_q;
    vert_d = vert_q;
    if (clr_i) begin
      hor_d  = '0;
      vert_d = '0;
    end else if (en_i) begin
      if (hor_end) begin
        hor_d  = '0;
        vert_d = vert_end ? '0 : vert_q + 1'b1;
      end else begin
        hor_d = hor_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hor_q  <= '0;
      vert_q <= '0;
    end else begin
      hor_q  <= hor_d;
      vert_q <= vert_d;
    end
  end

  assign hor_o  = hor_q;
  assign vert_o = vert_q;
  assign last_o = hor_end && vert_end;

endmodule

// File: rtl/stream_writeback.sv
// stream_writeback: frame sequencer and write-side address generator for the
// lattice streaming/collision step. Raster-scans the grid, issues the center
// coordinate on all 9 lanes, and produces the write enable / row-major write
// address aligned to the collided data, into the inactive ping-pong bank.
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-low reset
//   start_in         begin one frame (sampled only in IDLE)
//   stall_in         freeze the scan; in-flight cells keep draining
//   busy_out         high in SCAN and DRAIN, low in the done_out cycle
//   done_out         one-cycle pulse at frame completion
//   rd_valid_out     coordinate issued this cycle
//   hor_out/vert_out center coordinate replicated on all 9 lanes
//   rd_bank_out      bank being read
//   wr_en_out        write all 9 BRAMs this cycle
//   wr_addr_out      vert*HPIXELS+hor of the written cell
//   wr_bank_out      bank being written (~rd_bank_out)
//   frame_count_out  completed-frame counter, present only with FRAME_COUNT_EN
// Build option: `define FRAME_COUNT_EN adds frame_count_out.
module stream_writeback
  import lbm_pkg::*;
#(
  parameter int HPIXELS         = DEF_HPIXELS,
  parameter int VPIXELS         = DEF_VPIXELS,
  parameter int READ_LATENCY    = 3,
  parameter int COLLIDE_LATENCY = 4,
  localparam int HOR_SIZE  = $clog2(HPIXELS),
  localparam int VERT_SIZE = $clog2(VPIXELS),
  localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS),
  localparam int TOTAL_LAT = READ_LATENCY + COLLIDE_LATENCY
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 start_in,
  input  logic                                 stall_in,
  output logic                                 busy_out,
  output logic                                 done_out,
  output logic                                 rd_valid_out,
  output logic [NUM_DIRS-1:0][HOR_SIZE-1:0]    hor_out,
  output logic [NUM_DIRS-1:0][VERT_SIZE-1:0]   vert_out,
  output logic                                 rd_bank_out,
  output logic                                 wr_en_out,
  output logic [BRAM_SIZE-1:0]                 wr_addr_out,
  output logic                                 wr_bank_out
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0]                          frame_count_out
`endif
);

  // The registered address/enable output is the final delay stage, so the
  // tracking shift register is one shorter than TOTAL_LAT.
  localparam int unsigned SR_DEPTH = TOTAL_LAT - 1;
  localparam int unsigned SR_LAST  = SR_DEPTH - 1;

  state_e state_q, state_d;

  logic                 issue;
  logic                 done;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 cnt_last;
  logic [HOR_SIZE-1:0]  cnt_hor;
  logic [VERT_SIZE-1:0] cnt_vert;

  logic [SR_DEPTH-1:0]  sr_valid_q;
  logic [HOR_SIZE-1:0]  sr_hor_q  [SR_DEPTH];
  logic [VERT_SIZE-1:0] sr_vert_q [SR_DEPTH];

  logic                 wr_en_q;
  logic [BRAM_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic                 rd_bank_q, rd_bank_d;

  assign issue   = (state_q == SCAN) && !stall_in;
  assign cnt_clr = (state_q == IDLE) && start_in;
  // The counter stays on the last cell after it is issued so hor/vert hold
  // through DRAIN; the next start clears it.
  assign cnt_en  = issue && !cnt_last;

  raster_counter #(
    .HPIXELS (HPIXELS),
    .VPIXELS (VPIXELS)
  ) u_raster (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .hor_o  (cnt_hor),
    .vert_o (cnt_vert),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE:  if (start_in) state_d = SCAN;
      SCAN:  if (issue && cnt_last) state_d = DRAIN;
      DRAIN: begin
        if (!(|sr_valid_q) && !wr_en_q) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Tracking pipe shifts every cycle; stall bubbles travel as invalid slots.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sr_valid_q <= '0;
      for (int unsigned i = 0; i < SR_DEPTH; i++) begin
        sr_hor_q[i]  <= '0;
        sr_vert_q[i] <= '0;
      end
    end else begin
      sr_valid_q[0] <= issue;
      sr_hor_q[0]   <= cnt_hor;
      sr_vert_q[0]  <= cnt_vert;
      for (int unsigned i = 1; i < SR_DEPTH; i++) begin
        sr_valid_q[i] <= sr_valid_q[i-1];
        sr_hor_q[i]   <= sr_hor_q[i-1];
        sr_vert_q[i]  <= sr_vert_q[i-1];
      end
    end
  end

  assign wr_addr_d = BRAM_SIZE'(sr_vert_q[SR_LAST]) * BRAM_SIZE'(HPIXELS)
                   + BRAM_SIZE'(sr_hor_q[SR_LAST]);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q   <= sr_valid_q[SR_LAST];
      wr_addr_q <= wr_addr_d;
    end
  end

  assign rd_bank_d = done ? ~rd_bank_q : rd_bank_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rd_bank_q <= 1'b0;
    else         rd_bank_q <= rd_bank_d;
  end

`ifdef FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  assign frame_count_d = done ? frame_count_q + 16'd1 : frame_count_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) frame_count_q <= '0;
    else         frame_count_q <= frame_count_d;
  end

  assign frame_count_out = frame_count_q;
`endif

  assign busy_out     = (state_q == SCAN) || ((state_q == DRAIN) && !done);
  assign done_out     = done;
  assign rd_valid_out = issue;
  assign hor_out      = {NUM_DIRS{cnt_hor}};
  assign vert_out     = {NUM_DIRS{cnt_vert}};
  assign rd_bank_out  = rd_bank_q;
  assign wr_bank_out  = ~rd_bank_q;
  assign wr_en_out    = wr_en_q;
  assign wr_addr_out  = wr_addr_q;

endmodule
